// File: rtl/asyn_fifo_pkg.sv
// asyn_fifo_pkg -- shared constants for the single-clock FIFO.
//   DEFAULT_WIDTH      : default data word width in bits
//   DEFAULT_ADDR_WIDTH : default address width (depth = 2**ADDR_WIDTH)
package asyn_fifo_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

endpackage : asyn_fifo_pkg

// File: rtl/asyn_fifo_mem.sv
// asyn_fifo_mem -- 2**ADDR_WIDTH x WIDTH storage for asyn_fifo.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (clears the read register only)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; the read register loads only when set
//   raddr : read address
//   rdata : registered read data, holds when re=0
module asyn_fifo_mem
  import asyn_fifo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Synchronous write port; storage contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value whenever no read is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule : asyn_fifo_mem

// File: rtl/asyn_fifo.sv
// asyn_fifo -- single-clock FIFO with wrap-bit pointers.
// Optional feature: define ASYN_FIFO_LEVEL_EN to add the 'level' output.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst    : asynchronous active-high reset (pointers and rdata cleared)
//   wdata  : write data
//   winc   : write request, accepted when not full
//   wfull  : FIFO full
//   rdata  : registered read data, one cycle after an accepted read
//   rinc   : read request, accepted when not empty
//   rempty : FIFO empty
//   level  : stored word count 0..2**ADDR_WIDTH (ASYN_FIFO_LEVEL_EN only)
module asyn_fifo
  import asyn_fifo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                winc,
  output logic                wfull,
  output logic [WIDTH-1:0]    rdata,
  input  logic                rinc,
  output logic                rempty
`ifdef ASYN_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0] level
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wptr_r;
  logic [ADDR_WIDTH:0] rptr_r;
  logic                wr_accept_s;
  logic                rd_accept_s;
  logic                rempty_s;
  logic                wfull_s;

  // Equal pointers mean empty; same low bits on opposite laps mean full.
  assign rempty_s = (wptr_r == rptr_r);
  assign wfull_s  = (wptr_r[ADDR_WIDTH] != rptr_r[ADDR_WIDTH]) &&
                    (wptr_r[ADDR_WIDTH-1:0] == rptr_r[ADDR_WIDTH-1:0]);

  // Gating by the flags makes full+both accept only the read and
  // empty+both accept only the write, with no write-through.
  assign wr_accept_s = winc & ~wfull_s;
  assign rd_accept_s = rinc & ~rempty_s;

  // Pointer registers; they wrap naturally modulo 2**(ADDR_WIDTH+1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (wr_accept_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_accept_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  asyn_fifo_mem #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept_s),
    .waddr (wptr_r[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (rd_accept_s),
    .raddr (rptr_r[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  assign wfull  = wfull_s;
  assign rempty = rempty_s;

`ifdef ASYN_FIFO_LEVEL_EN
  // Modular difference gives 0..2**ADDR_WIDTH in ADDR_WIDTH+1 bits.
  assign level = wptr_r - rptr_r;
`endif

endmodule : asyn_fifo

// File: tb/tb_asyn_fifo.sv
// tb_asyn_fifo -- self-checking bench for asyn_fifo against a queue model.
// Define ASYN_FIFO_LEVEL_EN for both RTL and bench to exercise 'level'.
module tb_asyn_fifo;

  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic [WIDTH-1:0] rdata;
  logic             rinc;
  logic             rempty;
`ifdef ASYN_FIFO_LEVEL_EN
  logic [AW:0]      level;
`endif

  int               tests_run;
  int               tests_failed;
  string            phase;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_rdata;
  logic [WIDTH-1:0] stream_val;

  asyn_fifo #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wdata  (wdata),
    .winc   (winc),
    .wfull  (wfull),
    .rdata  (rdata),
    .rinc   (rinc),
    .rempty (rempty)
`ifdef ASYN_FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("rdata", 32'(rdata), 32'(exp_rdata));
    check("rempty", 32'(rempty), 32'(q.size() == 0));
    check("wfull", 32'(wfull), 32'(q.size() == DEPTH));
`ifdef ASYN_FIFO_LEVEL_EN
    check("level", 32'(level), 32'(q.size()));
`endif
  endtask

  // Called at a falling edge: drive, predict, cross one rising edge, check.
  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit wacc;
    bit racc;
    winc  = w;
    wdata = d;
    rinc  = r;
    wacc  = w && (q.size() < DEPTH);
    racc  = r && (q.size() > 0);
    @(posedge clk);
    if (racc) exp_rdata = q.pop_front();
    if (wacc) q.push_back(d);
    @(negedge clk);
    check_state();
  endtask

  task automatic model_reset();
    q.delete();
    exp_rdata = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    stream_val   = '0;
    rst   = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    model_reset();

    // Power-on reset
    phase = "por";
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_state();

    // Asynchronous reset with stimulus pending, no clock edge
    phase = "async_rst";
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 8'h4D, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    winc  = 1'b1;
    wdata = 8'h77;
    rst   = 1'b1;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    @(negedge clk);
    check_state();
    rst  = 1'b0;
    winc = 1'b0;

    // Fill 1..16, then a 17th write that must be ignored
    phase = "fill";
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'd17, 1'b0);

    // Drain 16 words in order, then an extra read that must hold rdata
    phase = "drain";
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("drain_last", 32'(rdata), 32'd16);

    // Streaming across many pointer wraps
    phase = "stream";
    for (int i = 0; i < 100; i++) begin
      bit w;
      bit r;
      w = (q.size() < DEPTH);
      r = (q.size() > 0);
      cycle(w, stream_val, r);
      if (w) stream_val = stream_val + 8'd1;
    end
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1);

    // Full boundary: simultaneous request reads one word, drops 0xAA
    phase = "full_both";
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 8'hA9)), 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1);

    // Empty boundary: simultaneous request writes 0x55 without write-through
    phase = "empty_both";
    cycle(1'b1, 8'h55, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("read_55", 32'(rdata), 32'h55);

    // Mid-operation reset pulse discards stored words
    phase = "mid_rst";
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    winc = 1'b0;
    rst  = 1'b1;
    #1;
    model_reset();
    check_state();
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_state();
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("read_33", 32'(rdata), 32'h33);

    // Randomized traffic, write-biased then read-biased
    phase = "random";
    for (int i = 0; i < 300; i++) begin
      bit w;
      bit r;
      if (i < 150) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      cycle(w, 8'($urandom), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_asyn_fifo
